uart_rom_loader: RTL and testbench



---
 rtl/uart_rom_loader_if.sv | 26 ++
 rtl/uart_rom_loader.sv | 140 ++++++++++++++
 tb/tb_uart_rom_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rom_loader_if.sv
// Bus between the UART byte source / top-level control and the ROM loader.
// The master drives the byte stream and session start; the slave reports ROM writes and status.
interface uart_rom_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  load_start;
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  rom_we;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [31:0]           rom_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output load_start, rx_valid, rx_byte,
    input  rom_we, rom_addr, rom_wdata, cpu_hold, done, error, words_loaded
  );

  modport slave (
    input  load_start, rx_valid, rx_byte,
    output rom_we, rom_addr, rom_wdata, cpu_hold, done, error, words_loaded
  );
endinterface

// File: rtl/uart_rom_loader.sv
// Packs UART bytes (MSB first) into 32-bit words and writes them sequentially into the
// instruction ROM, holding the CPU in reset while a load session is in progress.
module uart_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORDS      = 16,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic         clk,
  input  logic         rst,
  uart_rom_loader_if.slave bus_io
);

  // Sized to hold TIMEOUT+1 so the post-WRITE increment can never wrap.
  localparam int unsigned TmoW = $clog2(TIMEOUT + 2);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   OneWord = (ADDR_WIDTH + 1)'(1);
  localparam logic [TmoW-1:0]       TmoLim  = TmoW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [31:0]           shift_q, shift_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  error_q, error_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]           rom_wdata_q, rom_wdata_d;
  logic [TmoW-1:0]       tmo_inc;

  assign tmo_inc = tmo_q + TmoW'(1);

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    byte_cnt_d     = byte_cnt_q;
    word_idx_d     = word_idx_q;
    words_loaded_d = words_loaded_q;
    tmo_d          = tmo_q;
    error_d        = error_q;
    cpu_hold_d     = cpu_hold_q;
    rom_addr_d     = rom_addr_q;
    rom_wdata_d    = rom_wdata_q;

    // A restart wins over everything, including a byte arriving in the same cycle.
    if (bus_io.load_start) begin
      state_d        = StCollect;
      shift_d        = '0;
      byte_cnt_d     = '0;
      word_idx_d     = '0;
      words_loaded_d = '0;
      tmo_d          = '0;
      error_d        = 1'b0;
      cpu_hold_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCollect: begin
          if (bus_io.rx_valid) begin
            shift_d    = {shift_q[23:0], bus_io.rx_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
            tmo_d      = '0;
            if (byte_cnt_q == 2'd3) begin
              state_d     = StWrite;
              rom_addr_d  = word_idx_q;
              rom_wdata_d = {shift_q[23:0], bus_io.rx_byte};
            end
          end else begin
            tmo_d = tmo_inc;
            if (TIMEOUT != 0 && tmo_inc >= TmoLim) begin
              state_d    = StIdle;
              error_d    = 1'b1;
              cpu_hold_d = 1'b0;
              byte_cnt_d = '0;
            end
          end
        end
        StWrite: begin
          words_loaded_d = words_loaded_q + OneWord;
          if (word_idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
            state_d    = StCollect;
          end
          // The word is already latched, so this byte starts the next word.
          if (bus_io.rx_valid) begin
            shift_d    = {shift_q[23:0], bus_io.rx_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
            tmo_d      = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        StDone: begin
          cpu_hold_d = 1'b0;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      byte_cnt_q     <= '0;
      word_idx_q     <= '0;
      words_loaded_q <= '0;
      tmo_q          <= '0;
      error_q        <= 1'b0;
      cpu_hold_q     <= 1'b0;
      rom_addr_q     <= '0;
      rom_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      byte_cnt_q     <= byte_cnt_d;
      word_idx_q     <= word_idx_d;
      words_loaded_q <= words_loaded_d;
      tmo_q          <= tmo_d;
      error_q        <= error_d;
      cpu_hold_q     <= cpu_hold_d;
      rom_addr_q     <= rom_addr_d;
      rom_wdata_q    <= rom_wdata_d;
    end
  end

  assign bus_io.rom_we       = (state_q == StWrite);
  assign bus_io.done         = (state_q == StDone);
  assign bus_io.rom_addr     = rom_addr_q;
  assign bus_io.rom_wdata    = rom_wdata_q;
  assign bus_io.cpu_hold     = cpu_hold_q;
  assign bus_io.error        = error_q;
  assign bus_io.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader: single word, full session, timeout, restart,
// idle bytes and mid-session reset, all against hand-computed values.
module tb_uart_rom_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_rom_loader_if #(.ADDR_WIDTH(4)) bus ();

  uart_rom_loader #(
    .ADDR_WIDTH(4),
    .WORDS     (16),
    .TIMEOUT   (1000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int          we_cnt   = 0;
  int          done_cnt = 0;
  logic [3:0]  log_addr [64];
  logic [31:0] log_data [64];

  logic [31:0] rom_img [16] = '{
    32'h00100073, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C,
    32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'hDEADBEEF,
    32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'h55AA55AA,
    32'hAA55AA55, 32'h00000013, 32'hFEDCBA98, 32'h7FFFFFFF
  };

  // Log writes away from the active edge.
  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      if (we_cnt < 64) begin
        log_addr[we_cnt] = bus.rom_addr;
        log_data[we_cnt] = bus.rom_wdata;
      end
      we_cnt++;
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*(3-k) +: 8]);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"},    64'(bus.rom_we), 64'd0);
    check_eq({tag, "_addr"},  64'(bus.rom_addr), 64'd0);
    check_eq({tag, "_wdata"}, 64'(bus.rom_wdata), 64'd0);
    check_eq({tag, "_hold"},  64'(bus.cpu_hold), 64'd0);
    check_eq({tag, "_done"},  64'(bus.done), 64'd0);
    check_eq({tag, "_err"},   64'(bus.error), 64'd0);
    check_eq({tag, "_wl"},    64'(bus.words_loaded), 64'd0);
  endtask

  initial begin
    int base;
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_byte    = 8'h00;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Single word 0x00100073 with gaps between bytes
    pulse_load();
    check_eq("t1_hold", 64'(bus.cpu_hold), 64'd1);
    base = we_cnt;
    send_byte(8'h00); tick();
    send_byte(8'h10); tick();
    send_byte(8'h00); tick();
    check_eq("t1_no_early_we", 64'(we_cnt - base), 64'd0);
    send_byte(8'h73);
    check_eq("t1_we",    64'(bus.rom_we), 64'd1);
    check_eq("t1_addr",  64'(bus.rom_addr), 64'd0);
    check_eq("t1_wdata", 64'(bus.rom_wdata), 64'h00100073);
    check_eq("t1_hold2", 64'(bus.cpu_hold), 64'd1);
    tick();
    check_eq("t1_we_off", 64'(bus.rom_we), 64'd0);
    check_eq("t1_wl",     64'(bus.words_loaded), 64'd1);
    check_eq("t1_one_we", 64'(we_cnt - base), 64'd1);

    // Restart after 5 words plus 2 bytes
    for (int i = 1; i < 5; i++) send_word(rom_img[i]);
    send_byte(8'hAB);
    send_byte(8'hCD);
    tick();
    check_eq("t4_wl_before", 64'(bus.words_loaded), 64'd5);
    pulse_load();
    check_eq("t4_wl_reset", 64'(bus.words_loaded), 64'd0);
    base = we_cnt;
    send_word(32'h12345678);
    check_eq("t4_addr",  64'(bus.rom_addr), 64'd0);
    check_eq("t4_wdata", 64'(bus.rom_wdata), 64'h12345678);
    tick();
    check_eq("t4_wl", 64'(bus.words_loaded), 64'd1);
    check_eq("t4_one_we", 64'(we_cnt - base), 64'd1);

    // Full 16-word session, all 64 bytes back to back
    pulse_load();
    base     = we_cnt;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) send_word(rom_img[i]);
    check_eq("full_last_we", 64'(bus.rom_we), 64'd1);
    tick();
    check_eq("full_done",     64'(bus.done), 64'd1);
    check_eq("full_hold_dn",  64'(bus.cpu_hold), 64'd1);
    check_eq("full_wl",       64'(bus.words_loaded), 64'd16);
    tick();
    check_eq("full_done_off", 64'(bus.done), 64'd0);
    check_eq("full_hold_off", 64'(bus.cpu_hold), 64'd0);
    check_eq("full_addr_hold",  64'(bus.rom_addr), 64'd15);
    check_eq("full_wdata_hold", 64'(bus.rom_wdata), 64'h7FFFFFFF);
    tick();
    check_eq("full_we_cnt",   64'(we_cnt - base), 64'd16);
    check_eq("full_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("full_addr%0d", i), 64'(log_addr[base + i]), 64'(i));
      check_eq($sformatf("full_data%0d", i), 64'(log_data[base + i]), 64'(rom_img[i]));
    end

    // Timeout: 2 bytes then silence
    pulse_load();
    base = we_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < 999; i++) tick();
    check_eq("tmo_err_early", 64'(bus.error), 64'd0);
    check_eq("tmo_hold_early", 64'(bus.cpu_hold), 64'd1);
    tick();
    check_eq("tmo_err",  64'(bus.error), 64'd1);
    check_eq("tmo_hold", 64'(bus.cpu_hold), 64'd0);
    check_eq("tmo_no_we", 64'(we_cnt - base), 64'd0);
    check_eq("tmo_wl",   64'(bus.words_loaded), 64'd0);
    tick();
    check_eq("tmo_sticky", 64'(bus.error), 64'd1);
    pulse_load();
    check_eq("tmo_cleared", 64'(bus.error), 64'd0);
    check_eq("tmo_rearm",   64'(bus.cpu_hold), 64'd1);

    // Reset after the 3rd byte of word 2
    base = we_cnt;
    send_word(rom_img[0]);
    send_word(rom_img[1]);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_mid");
    tick();
    check_eq("rst_two_writes", 64'(we_cnt - base), 64'd2);

    // Bytes while idle are ignored; load_start beats a same-cycle byte
    base = we_cnt;
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h40 + i));
      tick();
    end
    check_eq("idle_no_we",   64'(we_cnt - base), 64'd0);
    check_eq("idle_no_hold", 64'(bus.cpu_hold), 64'd0);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hFF;
    pulse_load();
    bus.rx_valid = 1'b0;
    send_word(32'hDEADBEEF);
    check_eq("idle_addr",  64'(bus.rom_addr), 64'd0);
    check_eq("idle_wdata", 64'(bus.rom_wdata), 64'hDEADBEEF);
    tick();
    check_eq("idle_one_we", 64'(we_cnt - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
